div_dispatch: RTL and testbench
===============================

# div_dispatch

Issue and writeback wrapper that sits directly upstream of the M-extension iterative divider. It accepts DIV/DIVU/REM/REMU requests from the execute stage. It resolves divide-by-zero and signed overflow locally, and sends everything else to the divider as unsigned magnitudes. It then captures the divider result, applies sign correction, selects quotient or remainder, and holds the 32-bit result for writeback under a valid/ready handshake.

## Interface
- XLEN, 32, operand and result width.
- TAG_W, 5, width of the destination-register tag carried with each request.

- clock  in  1  single clock; all state on rising edge
- nreset  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request offered
- req_ready_o  out  1  block can accept a request
- req_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_a_i  in  XLEN  dividend (rs1)
- req_b_i  in  XLEN  divisor (rs2)
- req_tag_i  in  TAG_W  destination tag
- div_a_o  out  XLEN  dividend magnitude to divider
- div_b_o  out  XLEN  divisor magnitude to divider
- div_signed_o  out  1  divider signed mode; tied 0
- div_in_valid_o  out  1  operands valid to divider
- div_in_ready_i  in  1  divider accepts operands
- div_c_i  in  XLEN  divider quotient, valid only while div_out_valid_i && div_out_ready_o
- div_r_i  in  XLEN  divider remainder, same validity as div_c_i
- div_out_valid_i  in  1  divider result valid
- div_out_ready_o  out  1  block takes divider result
- res_valid_o  out  1  result valid
- res_ready_i  in  1  writeback accepts result
- res_data_o  out  XLEN  quotient or remainder
- res_tag_o  out  TAG_W  tag of the result

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch op, a, b and tag.
  - Compute neg_a = signed op & a[31], and neg_b = signed op & b[31].
  - Compute magnitudes: two's complement negate when negative, else pass through.
- Fast path, in IDLE:
  - Divide by zero (b == 0): quotient = all ones, remainder = a. Go to RESP.
  - Signed overflow (DIV/REM, a == 0x8000_0000, b == 0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0. Go to RESP.
- Normal path: go to ISSUE.
- ISSUE:
  - div_in_valid_o = 1, with div_a_o/div_b_o = latched magnitudes.
  - div_a_o/div_b_o stay stable until div_in_ready_i is seen high; then go to WAIT.
- WAIT:
  - div_out_ready_o = 1.
  - On div_out_valid_i, capture div_c_i and div_r_i in the same cycle; they are not guaranteed afterwards.
  - Quotient: negated if neg_a ^ neg_b.
  - Remainder: negated if neg_a.
  - Go to RESP.
- RESP:
  - res_valid_o = 1, with res_data_o = quotient for ops 00/01 and remainder for ops 10/11.
  - res_data_o and res_tag_o stay stable until res_ready_i. On res_valid_o && res_ready_i, go to IDLE.
- Only one operation in flight. req_ready_o is 0 in ISSUE, WAIT and RESP.
- Unsigned overflow does not exist. 0x8000_0000 as a signed magnitude negates to 0x8000_0000, which is correct as an unsigned magnitude.

## Timing
- All outputs are registered and derived from state and latched data. div_out_ready_o is decoded from state only.
- Reset values: req_ready_o 0 during reset and 1 in the first cycle after release. div_in_valid_o 0, div_out_ready_o 0, res_valid_o 0. res_data_o, res_tag_o, div_a_o and div_b_o all 0.
- Fast-path latency: res_valid_o rises 1 cycle after acceptance.
- Normal-path latency: 1 cycle to ISSUE, plus the divider handshake wait, plus divider compute. res_valid_o rises 1 cycle after the div_out_valid_i capture cycle.
- A new request can be accepted the cycle after the res handshake, when the FSM is back in IDLE.
- div_out_valid_i asserted outside WAIT is ignored; div_out_ready_o is 0 there.
- res_ready_i held high in advance still costs one RESP cycle.
- nreset asserted mid-operation returns to IDLE with all outputs at reset values. The divider shares nreset, so there is no orphaned transaction.

## Test plan
- DIVU a=100, b=7 -> divider sees 100/7, res_data_o=14. Repeat with REMU -> 2; res_tag_o matches the request tag.
- DIV a=-100 (0xFFFF_FF9C), b=7 -> div_a_o=100, res_data_o=-14 (0xFFFF_FFF2). REM with the same operands -> -2 (0xFFFF_FFFE).
- DIV a=5, b=0 -> no div_in_valid_o, res_valid_o one cycle after acceptance, data 0xFFFF_FFFF. REMU a=5, b=0 -> 5.
- DIV a=0x8000_0000, b=0xFFFF_FFFF -> fast path, 0x8000_0000. REM with the same operands -> 0.
- Backpressure:
  - Hold div_in_ready_i low for 3 cycles, then hold res_ready_i low for 4 cycles.
  - Operands and result must stay stable throughout, and req_ready_o must stay 0.
  - Exactly one result per request.
- Assert nreset while in WAIT -> all outputs reset. The next DIVU 9/3 -> 3.

Source files
------------

// File: rtl/div_dispatch.sv
// Issue/writeback wrapper for the iterative M-extension divider: resolves
// divide-by-zero and signed overflow locally, sign-corrects divider results.
module div_dispatch #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [XLEN-1:0]  req_a_i,
  input  logic [XLEN-1:0]  req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [XLEN-1:0]  div_a_o,
  output logic [XLEN-1:0]  div_b_o,
  output logic             div_signed_o,
  output logic             div_in_valid_o,
  input  logic             div_in_ready_i,
  input  logic [XLEN-1:0]  div_c_i,
  input  logic [XLEN-1:0]  div_r_i,
  input  logic             div_out_valid_i,
  output logic             div_out_ready_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [XLEN-1:0]  res_data_o,
  output logic [TAG_W-1:0] res_tag_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state;
  logic   rem_q, neg_a_q, neg_b_q;

  logic            signed_op, neg_a, neg_b, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b, q_fix, r_fix;

  // Divider always runs unsigned on magnitudes; INT_MIN negates to itself,
  // which is already the correct unsigned magnitude.
  always_comb begin
    signed_op = ~req_op_i[0];
    neg_a     = signed_op & req_a_i[XLEN-1];
    neg_b     = signed_op & req_b_i[XLEN-1];
    mag_a     = neg_a ? -req_a_i : req_a_i;
    mag_b     = neg_b ? -req_b_i : req_b_i;
    div0      = (req_b_i == '0);
    ovf       = signed_op && (req_a_i == INT_MIN) && (req_b_i == '1);
    q_fix     = (neg_a_q ^ neg_b_q) ? -div_c_i : div_c_i;
    r_fix     = neg_a_q ? -div_r_i : div_r_i;
  end

  assign div_signed_o = 1'b0;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state           <= IDLE;
      rem_q           <= 1'b0;
      neg_a_q         <= 1'b0;
      neg_b_q         <= 1'b0;
      req_ready_o     <= 1'b0;
      div_in_valid_o  <= 1'b0;
      div_out_ready_o <= 1'b0;
      res_valid_o     <= 1'b0;
      div_a_o         <= '0;
      div_b_o         <= '0;
      res_data_o      <= '0;
      res_tag_o       <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            rem_q       <= req_op_i[1];
            neg_a_q     <= neg_a;
            neg_b_q     <= neg_b;
            res_tag_o   <= req_tag_i;
            if (div0) begin
              res_data_o  <= req_op_i[1] ? req_a_i : '1;
              res_valid_o <= 1'b1;
              state       <= RESP;
            end else if (ovf) begin
              res_data_o  <= req_op_i[1] ? '0 : INT_MIN;
              res_valid_o <= 1'b1;
              state       <= RESP;
            end else begin
              div_a_o        <= mag_a;
              div_b_o        <= mag_b;
              div_in_valid_o <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (div_in_ready_i) begin
            div_in_valid_o  <= 1'b0;
            div_out_ready_o <= 1'b1;
            state           <= WAIT;
          end
        end
        WAIT: begin
          // Divider result is only valid in the handshake cycle.
          if (div_out_valid_i) begin
            div_out_ready_o <= 1'b0;
            res_data_o      <= rem_q ? r_fix : q_fix;
            res_valid_o     <= 1'b1;
            state           <= RESP;
          end
        end
        RESP: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_dispatch.sv
// Self-checking bench for div_dispatch: directed cases plus randomized ops
// against an arithmetic reference model and a behavioural divider.
module tb_div_dispatch;

  logic        clock = 1'b0;
  logic        nreset;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_a_i, req_b_i;
  logic [4:0]  req_tag_i;
  logic [31:0] div_a_o, div_b_o;
  logic        div_signed_o, div_in_valid_o, div_in_ready_i;
  logic [31:0] div_c_i, div_r_i;
  logic        div_out_valid_i, div_out_ready_o;
  logic        res_valid_o, res_ready_i;
  logic [31:0] res_data_o;
  logic [4:0]  res_tag_o;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  div_dispatch #(.XLEN(32), .TAG_W(5)) dut (
    .clock(clock), .nreset(nreset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_signed_o(div_signed_o),
    .div_in_valid_o(div_in_valid_o), .div_in_ready_i(div_in_ready_i),
    .div_c_i(div_c_i), .div_r_i(div_r_i),
    .div_out_valid_i(div_out_valid_i), .div_out_ready_o(div_out_ready_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_tag_o(res_tag_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic chk_all_reset();
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_in_valid", div_in_valid_o, 0);
    chk("rst_out_ready", div_out_ready_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_res_data", res_data_o, 0);
    chk("rst_res_tag", res_tag_o, 0);
    chk("rst_div_a", div_a_o, 0);
    chk("rst_div_b", div_b_o, 0);
    chk("div_signed", div_signed_o, 0);
  endtask

  // One complete transaction; all sampling on the falling edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int in_dly, input int cmp_dly,
                        input int res_dly, input bit res_adv);
    logic [31:0] exp_q, exp_r, exp_d, ma, mb;
    bit sgn, fast;
    sgn  = !op[0];
    fast = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (b == 0) begin
      exp_q = 32'hFFFF_FFFF; exp_r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      exp_q = 32'h8000_0000; exp_r = 0;
    end else if (sgn) begin
      exp_q = $signed(a) / $signed(b); exp_r = $signed(a) % $signed(b);
    end else begin
      exp_q = a / b; exp_r = a % b;
    end
    exp_d = op[1] ? exp_r : exp_q;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;

    @(negedge clock);
    chk("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1; req_op_i = op; req_a_i = a; req_b_i = b; req_tag_i = tag;
    res_ready_i = res_adv;
    @(negedge clock);
    req_valid_i = 0; req_a_i = $urandom; req_b_i = $urandom; req_tag_i = 5'($urandom);
    chk("req_ready_busy", req_ready_o, 0);
    if (!fast) begin
      chk("res_valid_early", res_valid_o, 0);
      for (int i = 0; i < in_dly; i++) begin
        chk("issue_valid", div_in_valid_o, 1);
        chk("issue_div_a", div_a_o, ma);
        chk("issue_div_b", div_b_o, mb);
        chk("issue_out_ready", div_out_ready_o, 0);
        chk("issue_req_ready", req_ready_o, 0);
        div_out_valid_i = 1; div_c_i = $urandom; div_r_i = $urandom;
        @(negedge clock);
      end
      div_out_valid_i = 0;
      chk("issue_valid", div_in_valid_o, 1);
      chk("issue_div_a", div_a_o, ma);
      chk("issue_div_b", div_b_o, mb);
      div_in_ready_i = 1;
      @(negedge clock);
      div_in_ready_i = 0;
      chk("in_valid_drop", div_in_valid_o, 0);
      for (int i = 0; i < cmp_dly; i++) begin
        chk("wait_out_ready", div_out_ready_o, 1);
        chk("wait_res_valid", res_valid_o, 0);
        @(negedge clock);
      end
      chk("wait_out_ready", div_out_ready_o, 1);
      div_out_valid_i = 1; div_c_i = ma / mb; div_r_i = ma % mb;
      @(negedge clock);
      div_out_valid_i = 0; div_c_i = $urandom; div_r_i = $urandom;
      chk("out_ready_drop", div_out_ready_o, 0);
    end else begin
      chk("fast_no_issue", div_in_valid_o, 0);
    end
    chk("res_valid", res_valid_o, 1);
    if (!res_adv) begin
      for (int i = 0; i < res_dly; i++) begin
        chk("resp_data_hold", res_data_o, exp_d);
        chk("resp_tag_hold", res_tag_o, tag);
        chk("resp_valid_hold", res_valid_o, 1);
        chk("resp_req_ready", req_ready_o, 0);
        @(negedge clock);
      end
    end
    chk("res_data", res_data_o, exp_d);
    chk("res_tag", res_tag_o, tag);
    res_ready_i = 1;
    @(negedge clock);
    res_ready_i = 0;
    chk("res_valid_drop", res_valid_o, 0);
    chk("req_ready_back", req_ready_o, 1);
  endtask

  function automatic logic [31:0] pick_val(input bit divisor);
    case ($urandom_range(0, 6))
      0: return divisor ? 32'h0 : 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(1, 50));
      3: return -32'($urandom_range(1, 50));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    nreset = 0; req_valid_i = 0; req_op_i = 0; req_a_i = 0; req_b_i = 0; req_tag_i = 0;
    div_in_ready_i = 0; div_c_i = 0; div_r_i = 0; div_out_valid_i = 0; res_ready_i = 0;
    repeat (3) @(negedge clock);
    chk_all_reset();
    nreset = 1;
    @(negedge clock);
    chk("ready_after_rst", req_ready_o, 1);

    run_op(2'b01, 32'd100, 32'd7, 5'd3, 0, 1, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 5'd17, 0, 0, 0, 0);
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd4, 1, 2, 1, 0);
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd5, 0, 0, 0, 0);
    run_op(2'b00, 32'd5, 32'd0, 5'd6, 0, 0, 0, 0);
    run_op(2'b11, 32'd5, 32'd0, 5'd7, 0, 0, 0, 1);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 0, 0, 1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, 0, 2, 0);
    run_op(2'b00, 32'h8000_0000, 32'd3, 5'd10, 0, 0, 0, 0);
    run_op(2'b10, 32'd77, 32'hFFFF_FFF6, 5'd11, 3, 2, 4, 0);

    // Reset while the divider is computing.
    @(negedge clock);
    req_valid_i = 1; req_op_i = 2'b01; req_a_i = 32'd1000; req_b_i = 32'd3; req_tag_i = 5'd21;
    @(negedge clock);
    req_valid_i = 0; div_in_ready_i = 1;
    @(negedge clock);
    div_in_ready_i = 0;
    chk("pre_rst_wait", div_out_ready_o, 1);
    nreset = 0;
    #1;
    chk_all_reset();
    @(negedge clock);
    nreset = 1;
    @(negedge clock);
    chk("ready_after_rst2", req_ready_o, 1);
    run_op(2'b01, 32'd9, 32'd3, 5'd30, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++)
      run_op(2'($urandom_range(0, 3)), pick_val(0), pick_val(1), 5'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
